// File: rtl/mreq_arbiter.sv
// Round-robin arbiter sharing one cmd_wb between N_REQ request masters.
// Latches the winning mreq and routes its rx/tx byte streams while busy.
module mreq_arbiter #(
    parameter int N_REQ      = 2,
    parameter int MREQ_WIDTH = 44,
    parameter int GRANT_W    = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            i_mreq_valid,
    output logic [N_REQ-1:0]            o_mreq_ready,
    input  logic [N_REQ*MREQ_WIDTH-1:0] i_mreq,
    input  logic [N_REQ*8-1:0]          i_rx_data,
    input  logic [N_REQ-1:0]            i_rx_valid,
    output logic [N_REQ-1:0]            o_rx_ready,
    output logic [N_REQ*8-1:0]          o_tx_data,
    output logic [N_REQ-1:0]            o_tx_valid,
    input  logic [N_REQ-1:0]            i_tx_ready,
    output logic                        o_mreq_valid,
    input  logic                        i_mreq_ready,
    output logic [MREQ_WIDTH-1:0]       o_mreq,
    output logic [7:0]                  o_rx_data,
    output logic                        o_rx_valid,
    input  logic                        i_rx_ready,
    input  logic [7:0]                  i_tx_data,
    input  logic                        i_tx_valid,
    output logic                        o_tx_ready,
    output logic                        o_busy,
    output logic [GRANT_W-1:0]          o_grant
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e                  state_q, state_d;
    logic [GRANT_W-1:0]      grant_q, grant_d;
    logic [GRANT_W-1:0]      ptr_q, ptr_d;
    logic [MREQ_WIDTH-1:0]   mreq_q, mreq_d;
    logic                    mreq_valid_q, mreq_valid_d;
    logic [GRANT_W-1:0]      winner;
    logic [GRANT_W:0]        scan;
    logic                    found;
    logic [MREQ_WIDTH-1:0]   mreq_sel;
    logic                    busy;

    assign busy = (state_q == BUSY);

    // Scan from ptr upward with wrap; one extra bit keeps ptr+i from overflowing.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan     = '0;
        mreq_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan = {1'b0, ptr_q} + (GRANT_W+1)'(i);
            if (scan >= (GRANT_W+1)'(N_REQ)) begin
                scan = scan - (GRANT_W+1)'(N_REQ);
            end
            if (!found && i_mreq_valid[scan[GRANT_W-1:0]]) begin
                found  = 1'b1;
                winner = scan[GRANT_W-1:0];
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (winner == GRANT_W'(k)) begin
                mreq_sel = i_mreq[k*MREQ_WIDTH +: MREQ_WIDTH];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        mreq_d       = mreq_q;
        mreq_valid_d = mreq_valid_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d      = winner;
                    mreq_d       = mreq_sel;
                    mreq_valid_d = 1'b1;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (mreq_valid_q && i_mreq_ready) begin
                    mreq_valid_d = 1'b0;
                    state_d      = IDLE;
                    if (grant_q == GRANT_W'(N_REQ-1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            ptr_q        <= '0;
            mreq_q       <= '0;
            mreq_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            mreq_q       <= mreq_d;
            mreq_valid_q <= mreq_valid_d;
        end
    end

    // Only the granted requester sees cmd_wb; everything else reads 0.
    always_comb begin
        o_mreq_ready = '0;
        o_rx_ready   = '0;
        o_tx_valid   = '0;
        o_tx_data    = '0;
        o_rx_data    = '0;
        o_rx_valid   = 1'b0;
        o_tx_ready   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (busy && grant_q == GRANT_W'(k)) begin
                o_mreq_ready[k]     = i_mreq_ready;
                o_rx_ready[k]       = i_rx_ready;
                o_tx_valid[k]       = i_tx_valid;
                o_tx_data[k*8 +: 8] = i_tx_data;
                o_rx_data           = i_rx_data[k*8 +: 8];
                o_rx_valid          = i_rx_valid[k];
                o_tx_ready          = i_tx_ready[k];
            end
        end
    end

    assign o_mreq_valid = mreq_valid_q;
    assign o_mreq       = mreq_q;
    assign o_busy       = busy;
    assign o_grant      = grant_q;

endmodule

// File: tb/tb_mreq_arbiter.sv
// Bench for mreq_arbiter (3 requesters): directed scenarios plus random
// traffic compared every cycle against a transaction-level reference model.
module tb_mreq_arbiter;

    localparam int N  = 3;
    localparam int MW = 44;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      i_mreq_valid = '0;
    logic [N-1:0]      o_mreq_ready;
    logic [N*MW-1:0]   i_mreq = '0;
    logic [N*8-1:0]    i_rx_data = '0;
    logic [N-1:0]      i_rx_valid = '0;
    logic [N-1:0]      o_rx_ready;
    logic [N*8-1:0]    o_tx_data;
    logic [N-1:0]      o_tx_valid;
    logic [N-1:0]      i_tx_ready = '0;
    logic              o_mreq_valid;
    logic              i_mreq_ready = 1'b0;
    logic [MW-1:0]     o_mreq;
    logic [7:0]        o_rx_data;
    logic              o_rx_valid;
    logic              i_rx_ready = 1'b0;
    logic [7:0]        i_tx_data = '0;
    logic              i_tx_valid = 1'b0;
    logic              o_tx_ready;
    logic              o_busy;
    logic [GW-1:0]     o_grant;

    int checks = 0;
    int errors = 0;

    mreq_arbiter #(.N_REQ(N), .MREQ_WIDTH(MW), .GRANT_W(GW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_mreq_valid(i_mreq_valid), .o_mreq_ready(o_mreq_ready),
        .i_mreq(i_mreq),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_mreq_valid(o_mreq_valid), .i_mreq_ready(i_mreq_ready),
        .o_mreq(o_mreq),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
        .o_busy(o_busy), .o_grant(o_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight, a rotating priority start.
    bit           m_busy = 1'b0;
    int           m_ptr = 0;
    int           m_grant = 0;
    logic [MW-1:0] m_payload = '0;
    int           max_ptr = 0;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int j = 0; j < N; j++) begin
            if (v[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_ptr     <= 0;
            m_grant   <= 0;
            m_payload <= '0;
        end else if (!m_busy) begin
            if (pick(i_mreq_valid, m_ptr) >= 0) begin
                m_grant   <= pick(i_mreq_valid, m_ptr);
                m_payload <= i_mreq[pick(i_mreq_valid, m_ptr)*MW +: MW];
                m_busy    <= 1'b1;
            end
        end else if (i_mreq_ready) begin
            m_busy <= 1'b0;
            m_ptr  <= (m_grant + 1) % N;
            if ((m_grant + 1) % N > max_ptr) max_ptr <= (m_grant + 1) % N;
        end
    end

    logic [N-1:0]   e_mrdy, e_rxrdy, e_txv;
    logic [N*8-1:0] e_txd;
    logic [7:0]     e_rxd;
    logic           e_rxv, e_txr;

    always @(negedge clk) begin
        e_mrdy  = '0;
        e_rxrdy = '0;
        e_txv   = '0;
        e_txd   = '0;
        e_rxd   = '0;
        e_rxv   = 1'b0;
        e_txr   = 1'b0;
        if (m_busy) begin
            e_mrdy[m_grant]       = i_mreq_ready;
            e_rxrdy[m_grant]      = i_rx_ready;
            e_txv[m_grant]        = i_tx_valid;
            e_txd[m_grant*8 +: 8] = i_tx_data;
            e_rxd                 = i_rx_data[m_grant*8 +: 8];
            e_rxv                 = i_rx_valid[m_grant];
            e_txr                 = i_tx_ready[m_grant];
        end
        chk("busy", 64'(o_busy), 64'(m_busy));
        chk("mreq_valid", 64'(o_mreq_valid), 64'(m_busy));
        chk("grant", 64'(o_grant), 64'(m_grant));
        chk("mreq", 64'(o_mreq), 64'(m_payload));
        chk("mreq_ready", 64'(o_mreq_ready), 64'(e_mrdy));
        chk("rx_ready", 64'(o_rx_ready), 64'(e_rxrdy));
        chk("tx_valid", 64'(o_tx_valid), 64'(e_txv));
        chk("tx_data", 64'(o_tx_data), 64'(e_txd));
        chk("rx_data", 64'(o_rx_data), 64'(e_rxd));
        chk("rx_valid", 64'(o_rx_valid), 64'(e_rxv));
        chk("tx_ready", 64'(o_tx_ready), 64'(e_txr));
    end

    task automatic wait_busy(input bit want, input string nm);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_busy == want) return;
        end
        chk(nm, 64'(o_busy), 64'(want));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [MW-1:0] P0 = 44'h9_2020_0000_10;
    int gseq[$];
    int exp_seq[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        do_reset();
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_grant", 64'(o_grant), 64'd0);

        // Single request from requester 0, payload latched and held.
        @(posedge clk); #1;
        i_mreq[0 +: MW] = P0;
        i_mreq_valid    = 3'b001;
        chk("lat_before", 64'(o_mreq_valid), 64'd0);
        @(posedge clk); #1;
        chk("lat_after", 64'(o_mreq_valid), 64'd1);
        chk("p0_payload", 64'(o_mreq), 64'(P0));
        chk("p0_grant", 64'(o_grant), 64'd0);
        i_mreq_valid    = 3'b000;
        i_mreq[0 +: MW] = 44'h123_4567_89AB;
        i_rx_valid      = 3'b011;
        i_rx_data       = 24'hBB_00AA;
        i_rx_ready      = 1'b1;
        #1;
        chk("p0_rx_data", 64'(o_rx_data), 64'hAA);
        chk("p0_rx_ready", 64'(o_rx_ready), 64'b001);
        @(posedge clk); #1;
        chk("p0_hold", 64'(o_mreq), 64'(P0));
        i_mreq_ready = 1'b1;
        #1;
        chk("p0_done", 64'(o_mreq_ready), 64'b001);
        @(posedge clk); #1;
        i_mreq_ready = 1'b0;
        i_rx_valid   = '0;
        i_rx_ready   = 1'b0;
        chk("p0_idle", 64'(o_busy), 64'd0);

        // Contention from reset: all valid, fixed order 0,1,2,0,1,2.
        do_reset();
        i_mreq_valid = 3'b111;
        i_mreq_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            wait_busy(1'b1, "rr_grant_timeout");
            gseq.push_back(int'(o_grant));
            wait_busy(1'b0, "rr_release_timeout");
        end
        for (int t = 0; t < 6; t++) begin
            chk("rr_order", 64'(gseq[t]), 64'(exp_seq[t]));
        end

        // Asynchronous reset in the middle of a transaction.
        i_mreq_ready = 1'b0;
        i_mreq_valid = 3'b110;
        wait_busy(1'b1, "ar_grant_timeout");
        i_rx_valid = '1;
        i_tx_ready = '1;
        i_tx_valid = 1'b1;
        i_rx_ready = 1'b1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("ar_valid", 64'(o_mreq_valid), 64'd0);
        chk("ar_busy", 64'(o_busy), 64'd0);
        chk("ar_streams", 64'({o_mreq_ready, o_rx_ready, o_tx_valid,
                               o_rx_valid, o_tx_ready}), 64'd0);
        @(negedge clk);
        rst          = 1'b0;
        i_mreq_valid = 3'b111;
        wait_busy(1'b1, "ar_regrant_timeout");
        chk("ar_first_grant", 64'(o_grant), 64'd0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            i_mreq_valid = N'($urandom);
            for (int k = 0; k < N; k++) begin
                i_mreq[k*MW +: MW] = {12'($urandom), 32'($urandom)};
            end
            i_mreq_ready = ($urandom_range(0, 3) == 0);
            i_rx_data    = (N*8)'($urandom);
            i_rx_valid   = N'($urandom);
            i_tx_ready   = N'($urandom);
            i_rx_ready   = 1'($urandom);
            i_tx_data    = 8'($urandom);
            i_tx_valid   = 1'($urandom);
        end
        @(negedge clk);
        chk("ptr_range", 64'(max_ptr <= N - 1), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
